// File: rtl/asip_pkg.sv
// Shared ASIP constants and the memory-write trace record layout.
// Also holds the saturating increment used by the drop counter.
package asip_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int SEQ_W  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with a registered occupancy counter.
// A pop on a full FIFO frees the slot that a same-cycle push then uses.
module sync_fifo_fwft #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic                     push_ok,
    output logic                     pop_ok,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rptr];

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (clear) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_ok) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop_ok) begin
                    rptr <= rptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_write_tracer.sv
// Captures memory-stage writes into a FWFT FIFO and drains them as
// sequence-tagged trace records; lost writes are flagged, never renumbered.
module mem_write_tracer #(
    parameter int DATA_W   = asip_pkg::DATA_W,
    parameter int ADDR_W   = asip_pkg::ADDR_W,
    parameter int DEPTH    = 16,
    parameter int SEQ_W    = asip_pkg::SEQ_W,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     memWriteM,
    input  logic [ADDR_W-1:0]        A,
    input  logic [DATA_W-1:0]        memWD,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [ADDR_W-1:0]        trace_addr,
    output logic [DATA_W-1:0]        trace_data,
    output logic [SEQ_W-1:0]         trace_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    import asip_pkg::sat_inc16;

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } rec_t;

    localparam int RW = $bits(rec_t);

    rec_t          rec_in;
    rec_t          rec_head;
    logic [SEQ_W-1:0] seq;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          pop_ok;
    logic          accept;
    logic          drop;
    logic [CW-1:0] count_next;

    assign rec_in = '{addr: A, data: memWD, seq: seq};

    sync_fifo_fwft #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (memWriteM),
        .pop        (trace_ready),
        .din        (rec_in),
        .head       (rec_head),
        .empty      (empty),
        .full       (full),
        .push_ok    (push_ok),
        .pop_ok     (pop_ok),
        .count      (count),
        .count_next (count_next)
    );

    assign accept = push_ok & ~clear;
    assign drop   = memWriteM & full & ~pop_ok & ~clear;

    // Head fields read as zero whenever nothing is queued, incl. after reset.
    assign trace_valid = ~empty;
    assign trace_addr  = trace_valid ? rec_head.addr : '0;
    assign trace_data  = trace_valid ? rec_head.data : '0;
    assign trace_seq   = trace_valid ? rec_head.seq  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq         <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            almost_full <= 1'b0;
        end else if (clear) begin
            seq         <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= CW'(AF_LEVEL));
            if (accept) begin
                seq <= seq + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc16(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mem_write_tracer.sv
// Directed bench for mem_write_tracer with a queue scoreboard of records.
module tb_mem_write_tracer;

    typedef struct packed {
        logic [15:0] addr;
        logic [23:0] data;
        logic [15:0] seq;
    } exp_rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        memWriteM = 1'b0;
    logic [15:0] A = '0;
    logic [23:0] memWD = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [15:0] trace_addr;
    logic [23:0] trace_data;
    logic [15:0] trace_seq;
    logic [4:0]  count;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    exp_rec_t    q[$];
    logic [15:0] mseq = '0;
    logic        mover = 1'b0;
    logic [15:0] mdrop = '0;

    mem_write_tracer dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .memWriteM   (memWriteM),
        .A           (A),
        .memWD       (memWD),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_seq   (trace_seq),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mseq  = '0;
        mover = 1'b0;
        mdrop = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, trace_valid, 0);
        check({tag, "_addr"}, trace_addr, 0);
        check({tag, "_data"}, trace_data, 0);
        check({tag, "_seq"}, trace_seq, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_af"}, almost_full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_drops"}, drop_cnt, 0);
    endtask

    task automatic step(input logic wr, input logic [15:0] a,
                        input logic [23:0] d, input logic rdy,
                        input logic clr);
        logic do_pop;
        logic do_push;
        logic do_drop;
        @(negedge clk);
        memWriteM   = wr;
        A           = a;
        memWD       = d;
        trace_ready = rdy;
        clear       = clr;
        #1;
        check("valid", trace_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("head_addr", trace_addr, q[0].addr);
            check("head_data", trace_data, q[0].data);
            check("head_seq", trace_seq, q[0].seq);
        end
        do_pop  = !clr && rdy && (q.size() != 0);
        do_push = !clr && wr && ((q.size() < 16) || do_pop);
        do_drop = !clr && wr && !do_push;
        @(posedge clk);
        #1;
        if (clr) begin
            model_clear();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back('{addr: a, data: d, seq: mseq});
                mseq++;
            end
            if (do_drop) begin
                mover = 1'b1;
                if (mdrop != 16'hFFFF) mdrop++;
            end
        end
        check("count", count, q.size());
        check("almost_full", almost_full, q.size() >= 12);
        check("overflow", overflow, mover);
        check("drop_cnt", drop_cnt, mdrop);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0, 24'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        memWriteM = 1'b0;
        trace_ready = 1'b0;
        clear = 1'b0;
        #1;
        model_clear();
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();

        // Single write, latency 1, drained next cycle
        step(1'b1, 16'h0010, 24'h00ABCD, 1'b1, 1'b0);
        check("single_valid", trace_valid, 1);
        check("single_addr", trace_addr, 16'h0010);
        check("single_data", trace_data, 24'h00ABCD);
        check("single_seq", trace_seq, 16'h0000);
        idle(1'b1);
        check("single_drained_valid", trace_valid, 0);
        check("single_drained_count", count, 0);

        // Fill to 16 with consumer stalled, then drop one
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i), 24'(i * 3), 1'b0, 1'b0);
            check("fill_af", almost_full, (i + 1) >= 12);
        end
        check("full_count", count, 16);
        step(1'b1, 16'h00FF, 24'h0000FF, 1'b0, 1'b0);
        check("drop_overflow", overflow, 1);
        check("drop_cnt_one", drop_cnt, 1);
        check("drop_count", count, 16);

        // Full with simultaneous push and pop
        step(1'b1, 16'h1234, 24'h55AA55, 1'b1, 1'b0);
        check("fullpp_count", count, 16);
        check("fullpp_drops", drop_cnt, 1);
        check("fullpp_tail_seq", q[15].seq, 16);

        // Head held stable under backpressure
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            check("hold_valid", trace_valid, 1);
        end

        // Drain in order (seq 1..16 after the earlier pop)
        while (q.size() != 0) idle(1'b1);
        check("drain_valid", trace_valid, 0);

        // Sequence wrap
        do_reset();
        for (int i = 0; i < 65534; i++) begin
            step(1'b1, 16'(i), 24'(i), 1'b1, 1'b0);
        end
        check("preload_seq", mseq, 16'hFFFE);
        step(1'b1, 16'hAAA0, 24'h000001, 1'b0, 1'b0);
        step(1'b1, 16'hAAA1, 24'h000002, 1'b0, 1'b0);
        step(1'b1, 16'hAAA2, 24'h000003, 1'b0, 1'b0);
        check("wrap_seq_0", q[q.size() - 3].seq, 16'hFFFE);
        check("wrap_seq_1", q[q.size() - 2].seq, 16'hFFFF);
        check("wrap_seq_2", q[q.size() - 1].seq, 16'h0000);
        while (q.size() != 0) idle(1'b1);

        // Asynchronous reset mid-cycle with 7 entries and overflow
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 16'(i + 100), 24'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("pre_rst_count", count, 7);
        check("pre_rst_ovf", overflow, 1);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Synchronous clear with a write in the same cycle
        for (int i = 0; i < 17; i++) step(1'b1, 16'(i + 200), 24'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("pre_clr_count", count, 7);
        check("pre_clr_ovf", overflow, 1);
        step(1'b1, 16'hDEAD, 24'hBEEF00, 1'b0, 1'b1);
        check_zero("clear");
        idle(1'b1);
        check("clear_write_gone", trace_valid, 0);
        step(1'b1, 16'h0042, 24'h000042, 1'b0, 1'b0);
        check("post_clear_seq", trace_seq, 0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_tracer.md
Name: mem_write_tracer

Overview:
- Downstream observer of the ASIP memory stage.
- Captures every data-memory write issued by the pipeline (memWriteM strobe, 16-bit address A, 24-bit write data) into a small FIFO.
- Drains the captured writes over a valid/ready port to the text-dump/trace consumer.
- Tags each record with a sequence number and flags lost records, so the dump is exact and cycle-independent.

Parameters:
- DATA_W, 24, width of memory write data.
- ADDR_W, 16, width of memory address.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SEQ_W, 16, width of the sequence tag.
- AF_LEVEL, 12, almost_full threshold in entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush of FIFO, seq counter and sticky flags.
- memWriteM  in  1  memory-stage write strobe; one record per high cycle.
- A  in  ADDR_W  memory-stage address.
- memWD  in  DATA_W  memory-stage write data.
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts head record.
- trace_addr  out  ADDR_W  head record address.
- trace_data  out  DATA_W  head record data.
- trace_seq  out  SEQ_W  head record sequence tag.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AF_LEVEL; core may use it as a stall request.
- overflow  out  1  sticky: a write was dropped since reset/clear.
- drop_cnt  out  16  dropped-write counter, saturating at 0xFFFF.

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, read/write pointers 0, seq counter 0, trace_valid 0, trace_addr/data/seq 0, count 0, almost_full 0, overflow 0, drop_cnt 0.
- Reset asserted mid-operation discards all stored records immediately.
- clear has the same effect as reset, synchronously at the clock edge, and takes priority over push and pop in that cycle.
- push = memWriteM; pop = trace_valid & trace_ready.
- Pushes are sampled at the rising edge.
- Accepted record = {A, memWD, seq}; seq then increments by 1, wrapping 0xFFFF -> 0x0000.
- Seq advances only on accepted pushes, so a gap in trace_seq never occurs; drops are reported only via overflow/drop_cnt.
- Output is first-word-fall-through. A push into an empty FIFO gives trace_valid=1 with the record on the outputs in the next cycle (latency 1).
- Head outputs are stable while trace_valid=1 and trace_ready=0.
- trace_valid never drops without a pop, clear or rst.
- Full (count==DEPTH) with push and no pop: record dropped; overflow set; drop_cnt +1 (saturating); seq unchanged.
- Full with push and pop in the same cycle: pop frees a slot, push accepted, count stays DEPTH, no drop.
- Empty with push and pop: pop is impossible (trace_valid=0); push accepted.
- Non-empty, non-full with push and pop: count unchanged, both take effect.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- count is derived as a separate registered counter, not from pointer difference.
- almost_full and count are registered and reflect post-edge occupancy.
- A and memWD are captured without width conversion. The upper 8 bits of any 24-bit consumer path are zero-extended by the consumer, not here.
- No combinational path from memWriteM to trace_valid.
- trace_ready→trace_valid path is combinational only through the pop decision, never within the same cycle.

Decomposition:
- Shared package (asip_pkg): ADDR_W=16, DATA_W=24, SEQ_W=16 constants and a packed typedef trace_rec_t {addr, data, seq}.
- One natural sub-module, sync_fifo_fwft: generic, parameterised by element type width and DEPTH. Provides push/pop/full/empty/count and head-of-queue output.
- mem_write_tracer itself holds the seq counter, drop/overflow logic, almost_full compare and the port mapping.

Test Plan:
- Reset then single write A=0x0010, memWD=0x00ABCD, trace_ready=1.
  -> Next cycle trace_valid=1, addr=0x0010, data=0x00ABCD, seq=0; the cycle after, trace_valid=0 and count=0.
- 16 back-to-back writes (A=i, data=i*3) with trace_ready=0.
  -> count=16, almost_full=1 from count 12.
  -> A 17th write is dropped: overflow=1, drop_cnt=1.
  -> Draining yields seq 0..15 in order with matching addr/data.
- Full FIFO, trace_ready=1 and memWriteM=1 in the same cycle.
  -> count stays 16, no drop, the new record appears at tail with seq=16.
- Hold trace_ready=0 for 5 cycles with valid head.
  -> trace_addr/data/seq unchanged across all 5 cycles; trace_valid stays 1.
- Preload seq to 0xFFFE via 65534 accepted writes drained at full rate, then 3 more writes.
  -> seq values 0xFFFE, 0xFFFF, 0x0000.
- Assert rst asynchronously mid-cycle with 7 entries and overflow=1.
  -> All outputs 0 immediately.
  -> Repeat with clear: same result at the next edge, and a write in the clear cycle is discarded.
